// File: rtl/apb_arbiter.sv
// ---------------------------------------------------------------------------
// apb_arbiter
//   Shares one APB completer path (the fabric) between two requesters: m0
//   (core) and m1 (debug/DMA). Grant is round-robin and is held for the whole
//   transfer. The arbiter regenerates the SETUP/ACCESS phasing toward the
//   fabric itself; a requester that is waiting sees pready low.
//
//   Optional feature macro: ARB_TIMEOUT_EN
//     When defined, an ACCESS phase that lasts TIMEOUT_CYCLES cycles without
//     s_pready is closed by the arbiter with pslverr=1 and prdata=0.
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   mN_psel/penable/paddr/    requester N (N=0,1) APB request; penable is
//   pwrite/pwdata/pwstrb        ignored because the arbiter sequences phases
//   mN_pready/prdata/pslverr  response to requester N (zero unless granted
//                               and completing)
//   s_psel/penable/paddr/     request toward the fabric
//   pwrite/pwdata/pwstrb
//   s_pready/prdata/pslverr   fabric response
// ---------------------------------------------------------------------------
module apb_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_psel,
  input  logic              m0_penable,
  input  logic [ADDR_W-1:0] m0_paddr,
  input  logic              m0_pwrite,
  input  logic [31:0]       m0_pwdata,
  input  logic [3:0]        m0_pwstrb,
  output logic              m0_pready,
  output logic [31:0]       m0_prdata,
  output logic              m0_pslverr,
  input  logic              m1_psel,
  input  logic              m1_penable,
  input  logic [ADDR_W-1:0] m1_paddr,
  input  logic              m1_pwrite,
  input  logic [31:0]       m1_pwdata,
  input  logic [3:0]        m1_pwstrb,
  output logic              m1_pready,
  output logic [31:0]       m1_prdata,
  output logic              m1_pslverr,
  output logic              s_psel,
  output logic              s_penable,
  output logic [ADDR_W-1:0] s_paddr,
  output logic              s_pwrite,
  output logic [31:0]       s_pwdata,
  output logic [3:0]        s_pwstrb,
  input  logic              s_pready,
  input  logic [31:0]       s_prdata,
  input  logic              s_pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   grant, grant_nxt;   // 0 = m0, 1 = m1
  logic   last, last_nxt;     // requester that completed most recently
  logic   gsel;               // psel of the currently granted requester
  logic   done;               // transfer completes this cycle
  logic   tmo;                // completion is forced by the timeout
  logic   timeout_hit;

  // The arbiter drives the phases itself, so requester penable is not used.
  logic unused_penable;
  assign unused_penable = m0_penable ^ m1_penable;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] count;

  // ACCESS wait counter: zero outside ACCESS, so it is clear on ACCESS entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (state != ACCESS) begin
      count <= '0;
    end else if (!s_pready) begin
      count <= count + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign timeout_hit = (state == ACCESS) && !s_pready &&
                       (count == CW'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // Granted requester's select, used to detect an abandoned transfer.
  always_comb begin
    gsel = grant ? m1_psel : m0_psel;
  end

  // State, grant and round-robin history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
    end
  end

  // Next-state, arbitration and completion decode.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    done      = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: begin
        if (m0_psel || m1_psel) begin
          state_nxt = SETUP;
          // On a tie the requester that did not finish last wins.
          if (m0_psel && m1_psel) begin
            grant_nxt = ~last;
          end else begin
            grant_nxt = m1_psel;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      SETUP: begin
        if (!gsel) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        // An abandoned transfer returns silently and leaves history alone.
        if (!gsel) begin
          state_nxt = IDLE;
        end else if (s_pready) begin
          done      = 1'b1;
          last_nxt  = grant;
          state_nxt = IDLE;
        end else if (timeout_hit) begin
          done      = 1'b1;
          tmo       = 1'b1;
          last_nxt  = grant;
          state_nxt = IDLE;
        end else begin
          state_nxt = ACCESS;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Fabric request mux and requester response steering.
  always_comb begin
    s_psel     = 1'b0;
    s_penable  = 1'b0;
    s_paddr    = '0;
    s_pwrite   = 1'b0;
    s_pwdata   = 32'h0000_0000;
    s_pwstrb   = 4'h0;
    m0_pready  = 1'b0;
    m0_prdata  = 32'h0000_0000;
    m0_pslverr = 1'b0;
    m1_pready  = 1'b0;
    m1_prdata  = 32'h0000_0000;
    m1_pslverr = 1'b0;
    if (state == SETUP || state == ACCESS) begin
      s_psel    = 1'b1;
      s_penable = (state == ACCESS);
      s_paddr   = grant ? m1_paddr  : m0_paddr;
      s_pwrite  = grant ? m1_pwrite : m0_pwrite;
      s_pwdata  = grant ? m1_pwdata : m0_pwdata;
      s_pwstrb  = grant ? m1_pwstrb : m0_pwstrb;
    end else begin
      s_psel    = 1'b0;
    end
    if (done) begin
      if (grant) begin
        m1_pready  = 1'b1;
        m1_prdata  = tmo ? 32'h0000_0000 : s_prdata;
        m1_pslverr = tmo ? 1'b1 : s_pslverr;
      end else begin
        m0_pready  = 1'b1;
        m0_prdata  = tmo ? 32'h0000_0000 : s_prdata;
        m0_pslverr = tmo ? 1'b1 : s_pslverr;
      end
    end else begin
      m0_pready = 1'b0;
    end
  end

endmodule
